serial_adder: RTL and testbench

Parametrised multi-cycle adder that reuses a SLICE-bit full-adder chain to add two WIDTH-bit operands over WIDTH/SLICE clock cycles.
- Carry is held in a register between slices.
- Start/busy/done handshake to the requesting logic.
- Successor to the single-bit combinational full adder: generalised in width and bits-per-cycle, adds sequencing, handshake and an optional subtract mode.
- Used where area matters more than latency.

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder: a SLICE-bit ripple chain adds two WIDTH-bit operands over WIDTH/SLICE cycles; SERIAL_ADDER_SUB_EN adds a subtract mode.
// Latency WIDTH/SLICE cycles from accepted start to done; start is ignored while busy (no queueing, no backpressure).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  logic [SLICE-1:0]   slice_sum;
  logic [SLICE:0]     chain_c;
  logic [WIDTH-1:0]   psum_shift;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               last_slice;

  // Subtraction is a + ~b + 1, so the B operand and carry seed are chosen at load time.
  always_comb begin
    b_load     = b;
    carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  always_comb begin
    slice_sum  = '0;
    chain_c    = '0;
    chain_c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      slice_sum[i]  = a_sh_q[i] ^ b_sh_q[i] ^ chain_c[i];
      chain_c[i+1]  = (a_sh_q[i] & b_sh_q[i]) | (chain_c[i] & (a_sh_q[i] ^ b_sh_q[i]));
    end
  end

  // Result bits enter from the top so that after N slices the LSB slice sits at bit 0.
  if (N == 1) begin : g_single
    assign psum_shift = slice_sum;
  end else begin : g_multi
    assign psum_shift = {slice_sum, psum_q[WIDTH-1:SLICE]};
  end

  assign last_slice = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> SLICE;
        b_sh_d  = b_sh_q >> SLICE;
        carry_d = chain_c[SLICE];
        psum_d  = psum_shift;
        cnt_d   = cnt_q + 1'b1;
        if (last_slice) begin
          sum_d   = psum_shift;
          cout_d  = chain_c[SLICE];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (SLICE 1, 4, 8) checked against an arithmetic model.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start  [3];
  logic [7:0] a_in   [3];
  logic [7:0] b_in   [3];
  logic       cin_in [3];
  logic       sub_in [3];
  logic       busy   [3];
  logic       done   [3];
  logic [7:0] sum    [3];
  logic       cout   [3];

  logic [7:0] last_sum  [3];
  logic       last_cout [3];
  int n_checks;
  int n_errors;

  serial_adder #(.WIDTH(8), .SLICE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a_in[0]), .b(b_in[0]), .cin(cin_in[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in[0]),
`endif
    .busy(busy[0]), .done(done[0]), .sum(sum[0]), .cout(cout[0]));

  serial_adder #(.WIDTH(8), .SLICE(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a_in[1]), .b(b_in[1]), .cin(cin_in[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in[1]),
`endif
    .busy(busy[1]), .done(done[1]), .sum(sum[1]), .cout(cout[1]));

  serial_adder #(.WIDTH(8), .SLICE(8)) u_s8 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a_in[2]), .b(b_in[2]), .cin(cin_in[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_in[2]),
`endif
    .busy(busy[2]), .done(done[2]), .sum(sum[2]), .cout(cout[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_slices(input int idx);
    case (idx)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: plain arithmetic; subtract gives a-b with cout meaning "no borrow".
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv, input logic sv);
    if (sv) return {(av >= bv), 8'(av - bv)};
    return 9'(av) + 9'(bv) + 9'(cv);
  endfunction

  task automatic issue(input int idx, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic sv, input bit hold);
    start[idx]  = 1'b1;
    a_in[idx]   = av;
    b_in[idx]   = bv;
    cin_in[idx] = cv;
    sub_in[idx] = sv;
    @(posedge clk); #1;
    if (!hold) start[idx] = 1'b0;
    a_in[idx]   = 8'($urandom);
    b_in[idx]   = 8'($urandom);
    cin_in[idx] = 1'($urandom);
    sub_in[idx] = 1'($urandom);
    check($sformatf("busy_after_accept[%0d]", idx), 32'(busy[idx]), 32'd1);
    check($sformatf("done_low_after_accept[%0d]", idx), 32'(done[idx]), 32'd0);
  endtask

  task automatic wait_done(input int idx, input logic [8:0] exp);
    int cyc = 0;
    int held_err = 0;
    int busy_err = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done[idx]) begin
        cyc = i;
        break;
      end
      if (sum[idx] !== last_sum[idx] || cout[idx] !== last_cout[idx]) held_err++;
      if (busy[idx] !== 1'b1) busy_err++;
    end
    check($sformatf("latency[%0d]", idx), 32'(cyc), 32'(n_slices(idx)));
    check($sformatf("result_held[%0d]", idx), 32'(held_err), 32'd0);
    check($sformatf("busy_during_run[%0d]", idx), 32'(busy_err), 32'd0);
    check($sformatf("busy_low_at_done[%0d]", idx), 32'(busy[idx]), 32'd0);
    check($sformatf("sum[%0d]", idx), 32'(sum[idx]), 32'(exp[7:0]));
    check($sformatf("cout[%0d]", idx), 32'(cout[idx]), 32'(exp[8]));
    last_sum[idx]  = exp[7:0];
    last_cout[idx] = exp[8];
  endtask

  task automatic op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                    input logic cv, input logic sv);
    logic [8:0] exp;
    exp = model(av, bv, cv, sv);
    issue(idx, av, bv, cv, sv, 1'b0);
    wait_done(idx, exp);
  endtask

  task automatic count_idle_pulses(input int idx, input int cycles, input string tag);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done[idx] || busy[idx]) pulses++;
    end
    check(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; a_in[i] = '0; b_in[i] = '0; cin_in[i] = 1'b0; sub_in[i] = 1'b0;
      last_sum[i] = '0; last_cout[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
      check($sformatf("rst_sum[%0d]", i), 32'(sum[i]), 32'd0);
      check($sformatf("rst_cout[%0d]", i), 32'(cout[i]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    count_idle_pulses(0, 2, "single_done_pulse");
    op(0, 8'hA5, 8'h5A, 1'b1, 1'b0);
    op(0, 8'h12, 8'h34, 1'b0, 1'b0);  // issued in the done cycle
    check("b2b_sum", 32'(sum[0]), 32'h46);
    op(1, 8'h3C, 8'h0F, 1'b0, 1'b0);
    op(2, 8'h3C, 8'h0F, 1'b0, 1'b0);

    // start held high with new operands while busy
    begin
      logic [8:0] exp;
      exp = model(8'h77, 8'h22, 1'b1, 1'b0);
      issue(0, 8'h77, 8'h22, 1'b1, 1'b0, 1'b1);
      a_in[0] = 8'h01;
      b_in[0] = 8'h01;
      wait_done(0, exp);
      start[0] = 1'b0;
      count_idle_pulses(0, 10, "no_extra_accept_while_busy");
    end

    // Asynchronous reset mid-run
    issue(0, 8'hC3, 8'h4D, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_done", 32'(done[0]), 32'd0);
    check("arst_sum", 32'(sum[0]), 32'd0);
    check("arst_cout", 32'(cout[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      last_sum[i] = '0; last_cout[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_idle_pulses(0, 10, "no_done_after_abort");
    op(0, 8'h10, 8'h20, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op(0, 8'h05, 8'h07, 1'b1, 1'b1);
    op(0, 8'h07, 8'h05, 1'b0, 1'b1);
    op(1, 8'h05, 8'h07, 1'b0, 1'b1);
    op(2, 8'h07, 8'h05, 1'b1, 1'b1);
`endif

    // Randomized operations, often back-to-back
    for (int idx = 0; idx < 3; idx++) begin
      for (int k = 0; k < 20; k++) begin
        logic sv;
        sv = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sv = 1'($urandom);
`endif
        op(idx, 8'($urandom), 8'($urandom), 1'($urandom), sv);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
